custom_shadow: RTL and testbench

- Snoops CPU writes to the custom chip register space (0xDFF000–0xDFF1FF) and keeps a 256×16 shadow copy, because those registers are write-only on the real chipset.
- Feeds the cartridge block's `custom_mirror_q` input, which the cartridge gates onto the bus for reads in its 0xA9Fxxx mirror window.
- SET/CLR-style registers are resolved by read-modify-write, so the shadow holds the effective register value rather than the raw write word.

---
 rtl/custom_shadow.sv | 184 ++++++++++++++++++
 tb/tb_custom_shadow.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/custom_shadow.sv
// custom_shadow: write-snooping shadow of the write-only custom chip
// registers at 0xDFF000-0xDFF1FF, kept as a 256x16 RAM.
//
// Ports:
//   clk, _rst        clock, asynchronous active-low reset
//   clk7_en          7 MHz enable; every register and the RAM advance only
//                    when it is high
//   cpu_address_in   CPU word address [23:1]
//   cpu_data_in      CPU write data
//   _cpu_as          CPU address strobe, active low
//   cpu_hwr/cpu_lwr  upper / lower byte write strobes
//   dbr              chipset DMA owns the bus, so the CPU cycle is not valid
//   custom_mirror_q  registered shadow word for cpu_address_in[8:1]
//   busy             high while clearing or doing a read-modify-write
module custom_shadow #(
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        _rst,
    input  logic        clk7_en,
    input  logic [23:1] cpu_address_in,
    input  logic [15:0] cpu_data_in,
    input  logic        _cpu_as,
    input  logic        cpu_hwr,
    input  logic        cpu_lwr,
    input  logic        dbr,
    output logic [15:0] custom_mirror_q,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_RMW_RD,
        S_RMW_WR,
        S_WAIT_END
    } state_t;

    localparam state_t RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

    state_t      state;
    state_t      nxt;

    logic [15:0] ram [256];

    logic [7:0]  idx;
    logic        cus_wr;
    logic        set_clr;

    logic [7:0]  cnt;
    logic [7:0]  lat_idx;
    logic [15:0] lat_data;
    logic [15:0] old;
    logic [15:0] mask;
    logic [15:0] rmw_val;

    logic        we_hi;
    logic        we_lo;
    logic        rd_en;
    logic [7:0]  waddr;
    logic [15:0] wdata;

    assign idx = cpu_address_in[8:1];

    assign cus_wr = ~dbr & ~_cpu_as & (cpu_hwr | cpu_lwr)
                  & (cpu_address_in[23:9] == 15'h6FF8);

    // DMACON, INTENA, INTREQ, ADKCON: bit 15 selects set or clear.
    assign set_clr = (idx == 8'h4B) | (idx == 8'h4D)
                   | (idx == 8'h4E) | (idx == 8'h4F);

    // The stored value never keeps bit 15: it is the SET/CLR control bit.
    assign mask    = {1'b0, lat_data[14:0]};
    assign rmw_val = (lat_data[15] ? (old | mask) : (old & ~mask))
                   & 16'h7FFF;

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state <= RST_STATE;
        end else if (clk7_en) begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_CLEAR: begin
                if (cnt == 8'hFF) begin
                    nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (cus_wr) begin
                    nxt = set_clr ? S_RMW_RD : S_WAIT_END;
                end
            end
            S_RMW_RD: nxt = S_RMW_WR;
            S_RMW_WR: nxt = S_WAIT_END;
            S_WAIT_END: begin
                // One update per bus cycle, however long the strobe lasts.
                if (_cpu_as) begin
                    nxt = S_IDLE;
                end
            end
            default: nxt = RST_STATE;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        we_hi = 1'b0;
        we_lo = 1'b0;
        rd_en = 1'b0;
        waddr = idx;
        wdata = cpu_data_in;
        unique case (state)
            S_CLEAR: begin
                busy  = 1'b1;
                we_hi = 1'b1;
                we_lo = 1'b1;
                waddr = cnt;
                wdata = 16'h0000;
            end
            S_IDLE: begin
                rd_en = 1'b1;
                if (cus_wr && !set_clr) begin
                    we_hi = cpu_hwr;
                    we_lo = cpu_lwr;
                end
            end
            S_RMW_RD: busy = 1'b1;
            S_RMW_WR: begin
                busy  = 1'b1;
                we_hi = 1'b1;
                we_lo = 1'b1;
                waddr = lat_idx;
                wdata = rmw_val;
            end
            S_WAIT_END: rd_en = 1'b1;
            default: busy = 1'b0;
        endcase
        // Reset kills the write at once, not at the next edge.
        if (!(clk7_en && _rst)) begin
            we_hi = 1'b0;
            we_lo = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (we_hi) begin
            ram[waddr][15:8] <= wdata[15:8];
        end
        if (we_lo) begin
            ram[waddr][7:0] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            cnt             <= 8'h00;
            lat_idx         <= 8'h00;
            lat_data        <= 16'h0000;
            old             <= 16'h0000;
            custom_mirror_q <= 16'h0000;
        end else if (clk7_en) begin
            if (state == S_CLEAR) begin
                cnt <= cnt + 8'd1;
            end
            if (state == S_IDLE && cus_wr && set_clr) begin
                lat_idx  <= idx;
                lat_data <= cpu_data_in;
            end
            if (state == S_RMW_RD) begin
                old <= ram[lat_idx];
            end
            // Nonblocking read: a same-cycle write returns the old word.
            if (rd_en) begin
                custom_mirror_q <= ram[idx];
            end
        end
    end

endmodule

// File: tb/tb_custom_shadow.sv
// tb_custom_shadow: randomized scoreboard bench for custom_shadow.
// Driver queues expectations; a negedge monitor pops and compares them.
module tb_custom_shadow;

    logic        clk = 1'b0;
    logic        clk7_en = 1'b0;
    logic        _rst;
    logic [23:1] cpu_address_in;
    logic [15:0] cpu_data_in;
    logic        _cpu_as;
    logic        cpu_hwr;
    logic        cpu_lwr;
    logic        dbr;
    logic [15:0] custom_mirror_q;
    logic        busy;

    custom_shadow #(.CLEAR_ON_RESET(1'b1)) dut (
        .clk            (clk),
        ._rst           (_rst),
        .clk7_en        (clk7_en),
        .cpu_address_in (cpu_address_in),
        .cpu_data_in    (cpu_data_in),
        ._cpu_as        (_cpu_as),
        .cpu_hwr        (cpu_hwr),
        .cpu_lwr        (cpu_lwr),
        .dbr            (dbr),
        .custom_mirror_q(custom_mirror_q),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) clk7_en <= ($urandom_range(0, 3) != 0);

    // kind 0: compare custom_mirror_q, 1: compare busy, 2: compare act
    typedef struct {
        string       nm;
        int          kind;
        logic [15:0] exp;
        logic [15:0] act;
    } item_t;

    item_t       sb [1024];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          total = 0;
    int          bad = 0;
    item_t       cur;
    logic [15:0] got;

    // Reference shadow of the register file.
    logic [15:0] mdl [256];

    always @(negedge clk) begin
        while (rd_ptr < wr_ptr) begin
            cur = sb[rd_ptr];
            if (cur.kind == 0) got = custom_mirror_q;
            else if (cur.kind == 1) got = {15'b0, busy};
            else got = cur.act;
            total++;
            if (got !== cur.exp) begin
                bad++;
                $display("FAIL %s: got %h want %h", cur.nm, got, cur.exp);
            end
            rd_ptr++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic push(input string nm, input int kind,
                        input logic [15:0] exp, input logic [15:0] act);
        sb[wr_ptr].nm   = nm;
        sb[wr_ptr].kind = kind;
        sb[wr_ptr].exp  = exp;
        sb[wr_ptr].act  = act;
        wr_ptr++;
    endtask

    task automatic step7();
        int guard = 0;
        bit hit = 1'b0;
        while (!hit) begin
            @(posedge clk);
            hit = clk7_en;
            guard++;
            if (guard > 1000) begin
                $display("FAIL step7: got %0d edges want <1000", guard);
                $fatal(1, "clock enable stuck");
            end
        end
        #1;
    endtask

    function automatic bit is_setclr(input logic [7:0] i);
        return i == 8'h4B || i == 8'h4D || i == 8'h4E || i == 8'h4F;
    endfunction

    function automatic bit valid_wr(input logic [22:0] wa, input bit h,
                                    input bit l, input bit db);
        return !db && (h || l) && (wa[22:8] == 15'h6FF8);
    endfunction

    task automatic model_wr(input logic [22:0] wa, input logic [15:0] d,
                            input bit h, input bit l, input bit db);
        logic [7:0]  i;
        logic [15:0] v;
        i = wa[7:0];
        if (!valid_wr(wa, h, l, db)) return;
        v = mdl[i];
        if (is_setclr(i)) begin
            if (d[15]) v = v | {1'b0, d[14:0]};
            else v = v & ~{1'b0, d[14:0]};
            v[15] = 1'b0;
        end else begin
            if (h) v[15:8] = d[15:8];
            if (l) v[7:0] = d[7:0];
        end
        mdl[i] = v;
    endtask

    task automatic bus_idle();
        _cpu_as = 1'b1;
        cpu_hwr = 1'b0;
        cpu_lwr = 1'b0;
        dbr     = 1'b0;
    endtask

    task automatic clear_mdl();
        for (int i = 0; i < 256; i++) mdl[i] = 16'h0000;
    endtask

    // Hold the strobe for 'hold' enabled edges, scrambling the data after
    // the first one so a second update would show.
    task automatic cpu_wr(input logic [22:0] wa, input logic [15:0] d,
                          input bit h, input bit l, input bit db,
                          input int hold, output int bc);
        bc = 0;
        cpu_address_in = wa;
        cpu_data_in    = d;
        cpu_hwr        = h;
        cpu_lwr        = l;
        dbr            = db;
        _cpu_as        = 1'b0;
        for (int k = 0; k < hold; k++) begin
            step7();
            if (busy) bc++;
            if (k == 0) begin
                push("rbw_q", 0, mdl[wa[7:0]], 16'h0);
                cpu_data_in = ~d;
            end
        end
        bus_idle();
        for (int k = 0; k < 3; k++) begin
            step7();
            if (busy) bc++;
        end
        model_wr(wa, d, h, l, db);
    endtask

    task automatic rd(input logic [22:0] wa, input string nm);
        cpu_address_in = wa;
        bus_idle();
        step7();
        push(nm, 0, mdl[wa[7:0]], 16'h0);
    endtask

    task automatic wait_clear(input string nm, input bit inject);
        int n = 0;
        while (busy && n < 1000) begin
            step7();
            n++;
            if (inject && n == 10) begin
                cpu_address_in = 23'h6FF8C0;
                cpu_data_in    = 16'h1234;
                cpu_hwr        = 1'b1;
                cpu_lwr        = 1'b1;
                _cpu_as        = 1'b0;
            end
            if (inject && n == 13) bus_idle();
        end
        push(nm, 2, 16'd256, 16'(n));
    endtask

    initial begin
        int          bc;
        logic [22:0] wa;
        logic [15:0] d;
        bit          h, l, db, sc;
        int          hold;

        _rst           = 1'b0;
        cpu_address_in = '0;
        cpu_data_in    = '0;
        bus_idle();
        clear_mdl();

        repeat (3) @(posedge clk);
        #1;
        push("rst_q", 0, 16'h0000, 16'h0);
        push("rst_busy", 1, 16'h0001, 16'h0);
        @(posedge clk);
        #1;
        _rst = 1'b1;
        wait_clear("clear_len", 1'b1);

        rd(23'h6FF880, "rd_80_zero");
        rd(23'h6FF8C0, "clear_wr_dropped");

        cpu_wr(23'h6FF8C0, 16'h0F00, 1, 1, 0, 4, bc);
        push("word_busy", 2, 16'd0, 16'(bc));
        rd(23'h6FF8C0, "word_wr");

        cpu_wr(23'h6FF8C0, 16'h12AB, 0, 1, 0, 2, bc);
        rd(23'h6FF8C0, "byte_wr");

        cpu_wr(23'h6FF84D, 16'hC028, 1, 1, 0, 4, bc);
        push("intena_set_busy", 2, 16'd2, 16'(bc));
        rd(23'h6FF84D, "intena_set");
        cpu_wr(23'h6FF84D, 16'h0008, 1, 0, 0, 2, bc);
        push("intena_clr_busy", 2, 16'd2, 16'(bc));
        rd(23'h6FF84D, "intena_clr");

        cpu_wr(23'h6FF8C0, 16'hBEEF, 1, 1, 1, 3, bc);
        rd(23'h6FF8C0, "filt_dbr");
        cpu_wr(23'h6FF900, 16'hBEEF, 1, 1, 0, 2, bc);
        rd(23'h6FF800, "filt_range");
        cpu_wr(23'h6FF8C0, 16'hBEEF, 0, 0, 0, 2, bc);
        rd(23'h6FF8C0, "filt_nostrobe");

        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 9) < 3)
                wa = {15'h6FF8, 6'b010011, 2'($urandom_range(0, 3))};
            else
                wa = {15'h6FF8, 8'($urandom_range(0, 255))};
            if ($urandom_range(0, 9) == 0) wa[8] = 1'b1;
            if (wa[7:0] == 8'h4C) wa[7:0] = 8'h4B;
            d    = 16'($urandom);
            h    = 1'($urandom_range(0, 1));
            l    = 1'($urandom_range(0, 1));
            db   = ($urandom_range(0, 6) == 0);
            hold = $urandom_range(1, 4);
            sc   = valid_wr(wa, h, l, db) && is_setclr(wa[7:0]);
            cpu_wr(wa, d, h, l, db, hold, bc);
            push("rnd_busy", 2, sc ? 16'd2 : 16'd0, 16'(bc));
            rd(wa, "rnd_rd");
            rd({15'h6FF8, 8'($urandom_range(0, 255))}, "rnd_rd2");
        end

        cpu_wr(23'h6FF84B, 16'h8003, 1, 1, 0, 1, bc);
        rd(23'h6FF84B, "dmacon_set");

        cpu_address_in = 23'h6FF84B;
        cpu_data_in    = 16'h8050;
        cpu_hwr        = 1'b1;
        cpu_lwr        = 1'b1;
        _cpu_as        = 1'b0;
        step7();
        push("rmw_busy", 1, 16'h0001, 16'h0);
        _rst = 1'b0;
        #1;
        push("midrst_q", 0, 16'h0000, 16'h0);
        push("midrst_busy", 1, 16'h0001, 16'h0);
        bus_idle();
        repeat (5) @(posedge clk);
        #1;
        _rst = 1'b1;
        clear_mdl();
        wait_clear("clear_len2", 1'b0);
        rd(23'h6FF84B, "rmw_target");
        rd(23'h6FF84D, "after_clear");

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
